// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between loader, data and fetch ports; grants same cycle, read data 1 cycle later.
// Losing requesters are not queued and must hold their request; fetch is protected by a starvation guard in RUN.
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             boot_done,
  input  logic             halted,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DW-1:0]    ld_wdata,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ID_LD = 2'd0,
    ID_DM = 2'd1,
    ID_IF = 2'd2
  } id_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        st;
  logic [SW-1:0] starve_cnt;
  logic          if_due;
  logic          tag_vld;
  id_t           tag_id;

  assign state  = st;
  assign if_due = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    ld_gnt = 1'b0;
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!reset) begin
      case (st)
        BOOT: ld_gnt = ld_req;
        RUN: begin
          // DM normally wins a conflict; a starved fetch gets exactly one turn
          if (dm_req && (!if_req || !if_due)) dm_gnt = 1'b1;
          else                                if_gnt = if_req;
        end
        HALT: begin
          if (ld_req) ld_gnt = 1'b1;
          else        dm_gnt = dm_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign mem_en = ld_gnt | dm_gnt | if_gnt;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      st           <= BOOT;
      starve_cnt   <= '0;
      conflict_cnt <= '0;
      tag_vld      <= 1'b0;
      tag_id       <= ID_LD;
    end else begin
      // the tag follows the grant, not the FSM, so reads survive state changes
      tag_vld <= mem_en && !mem_we;
      tag_id  <= ld_gnt ? ID_LD : (dm_gnt ? ID_DM : ID_IF);

      if (st == RUN && if_req && !if_gnt) starve_cnt <= starve_cnt + 1'b1;
      else                                starve_cnt <= '0;

      if (st == RUN && dm_req && if_req && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;

      case (st)
        BOOT:    if (boot_done) st <= RUN;
        RUN:     if (halted)    st <= HALT;
        HALT:    if (ld_req)    st <= BOOT;
        default: st <= BOOT;
      endcase
    end
  end

  assign ld_rvalid = tag_vld && (tag_id == ID_LD);
  assign dm_rvalid = tag_vld && (tag_id == ID_DM);
  assign if_rvalid = tag_vld && (tag_id == ID_IF);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural reference model checked every cycle.
module tb_mem_port_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int CW  = 16;

  logic          clk1 = 1'b0;
  logic          reset = 1'b1;
  logic          boot_done = 1'b0, halted = 1'b0;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    state;
  logic [CW-1:0] conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk1(clk1), .reset(reset), .boot_done(boot_done), .halted(halted),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state), .conflict_cnt(conflict_cnt)
  );

  always #5 clk1 = ~clk1;

  // synchronous single-port memory with 1-cycle read latency
  logic [DW-1:0] mem [1024];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: sampled at negedge while inputs are stable for the coming posedge
  initial begin
    int            m_st, streak, conf, pid;
    bit            pv, e_ld, e_dm, e_if, e_we;
    logic [31:0]   pdat, e_addr, e_wd;
    logic [31:0]   sh [1024];
    m_st = 0; streak = 0; conf = 0; pid = 0; pv = 0; pdat = '0;
    forever begin
      @(negedge clk1);
      if (reset) begin
        m_st = 0; streak = 0; conf = 0; pv = 0;
      end
      e_ld = 0; e_dm = 0; e_if = 0;
      if (!reset) begin
        if (m_st == 0) e_ld = ld_req;
        else if (m_st == 1) begin
          if (dm_req && if_req) begin
            if (streak >= LIM) e_if = 1;
            else               e_dm = 1;
          end else begin
            e_dm = dm_req;
            e_if = if_req;
          end
        end else begin
          if (ld_req) e_ld = 1;
          else        e_dm = dm_req;
        end
      end
      chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      chk("if_gnt", 32'(if_gnt), 32'(e_if));
      chk("mem_en", 32'(mem_en), 32'(e_ld | e_dm | e_if));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(pv && pid == 0));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(pv && pid == 1));
      chk("if_rvalid", 32'(if_rvalid), 32'(pv && pid == 2));
      if (pv) chk("rdata", rdata, pdat);
      chk("state", 32'(state), 32'(m_st));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(conf));

      e_we = 0; e_addr = '0; e_wd = '0;
      if (e_ld)      begin e_we = ld_we; e_addr = 32'(ld_addr); e_wd = ld_wdata; end
      else if (e_dm) begin e_we = dm_we; e_addr = 32'(dm_addr); e_wd = dm_wdata; end
      else if (e_if) begin e_addr = 32'(if_addr); end
      if (e_ld | e_dm | e_if) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wd);
      end

      pv = 0;
      if (!reset) begin
        if (e_ld | e_dm | e_if) begin
          if (e_we) sh[e_addr[AW-1:0]] = e_wd;
          else begin
            pv   = 1;
            pid  = e_ld ? 0 : (e_dm ? 1 : 2);
            pdat = sh[e_addr[AW-1:0]];
          end
        end
        if (m_st == 1 && dm_req && if_req && conf < 65535) conf++;
        streak = (m_st == 1 && if_req && !e_if) ? streak + 1 : 0;
        case (m_st)
          0: if (boot_done) m_st = 1;
          1: if (halted)    m_st = 2;
          default: if (ld_req) m_st = 0;
        endcase
      end
    end
  end

  task automatic half();
    @(negedge clk1);
  endtask

  task automatic fin();
    @(posedge clk1);
    #1;
  endtask

  task automatic ld_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    half();
    chk("boot_ld_gnt", 32'(ld_gnt), 32'd1);
    fin();
  endtask

  initial begin
    logic [9:0] pat;
    pat = '0;
    repeat (2) fin();
    half();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    fin();
    reset = 1'b0;

    // boot load
    ld_op(1'b1, 10'd0,   32'h280a00c8);
    ld_op(1'b1, 10'd5,   32'h14431000);
    ld_op(1'b1, 10'd200, 32'd5);
    ld_op(1'b0, 10'd200, 32'd0);
    ld_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd0;
    half();
    chk("boot_ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("boot_rdata", rdata, 32'd5);
    chk("boot_dm_ignored", 32'(dm_gnt), 32'd0);
    fin();
    dm_req = 1'b0;
    boot_done = 1'b1;
    fin();
    boot_done = 1'b0;

    // sustained conflict
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200;
    if_req = 1'b1; if_addr = 10'd5;
    for (int i = 0; i < 10; i++) begin
      half();
      pat[i] = if_gnt;
      fin();
    end
    chk("conflict_order", 32'(pat), 32'(10'b1000010000));
    dm_req = 1'b0; if_req = 1'b0;
    half();
    chk("conflict_cnt10", 32'(conflict_cnt), 32'd10);
    fin();

    // read routing
    if_req = 1'b1; if_addr = 10'd5;
    half();
    chk("route_if_gnt", 32'(if_gnt), 32'd1);
    fin();
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200;
    half();
    chk("route_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("route_if_rdata", rdata, 32'h14431000);
    chk("route_dm_rvalid0", 32'(dm_rvalid), 32'd0);
    fin();
    dm_req = 1'b0;
    half();
    chk("route_dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("route_if_rvalid0", 32'(if_rvalid), 32'd0);
    chk("route_dm_rdata", rdata, 32'd5);
    fin();

    // halt with a store in flight
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd198; dm_wdata = 32'd120;
    if_req = 1'b1; halted = 1'b1;
    half();
    chk("halt_dm_gnt", 32'(dm_gnt), 32'd1);
    fin();
    halted = 1'b0; dm_we = 1'b0;
    half();
    chk("halt_state", 32'(state), 32'd2);
    chk("halt_if_gnt", 32'(if_gnt), 32'd0);
    chk("halt_dm_read_gnt", 32'(dm_gnt), 32'd1);
    fin();
    dm_req = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd198;
    half();
    chk("halt_dm_rdata", rdata, 32'd120);
    chk("reboot_ld_gnt", 32'(ld_gnt), 32'd1);
    fin();
    ld_req = 1'b0; if_req = 1'b0;
    dm_req = 1'b1;
    half();
    chk("reboot_state", 32'(state), 32'd0);
    chk("reboot_ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("reboot_rdata", rdata, 32'd120);
    chk("reboot_dm_ignored", 32'(dm_gnt), 32'd0);
    fin();
    dm_req = 1'b0;

    // reset while a read is outstanding
    boot_done = 1'b1;
    fin();
    boot_done = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200;
    half();
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd1);
    fin();
    reset = 1'b1; dm_req = 1'b0;
    half();
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    fin();
    reset = 1'b0;
    half();
    chk("rst_dm_rvalid_after", 32'(dm_rvalid), 32'd0);
    fin();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
